// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - opcode/func constants, FSM state and datapath select codes for mc_ctrl
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_OR  = 2'd2,
        ALU_LUI = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        WA_RD = 2'd0,
        WA_RT = 2'd1,
        WA_RA = 2'd2
    } wa_sel_e;

    typedef enum logic [1:0] {
        WD_ALU = 2'd0,
        WD_MDR = 2'd1,
        WD_PC  = 2'd2
    } wd_sel_e;

    // Exactly one field is set for any instruction word.
    typedef struct packed {
        logic rtype_alu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
        logic jr;
        logic unknown;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/func to one-hot instruction class
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] fn,
    output iclass_t    cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB: cls.rtype_alu = 1'b1;
                    FN_JR:          cls.jr        = 1'b1;
                    default:        cls.unknown   = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori     = 1'b1;
            OP_LUI:  cls.lui     = 1'b1;
            OP_LW:   cls.lw      = 1'b1;
            OP_SW:   cls.sw      = 1'b1;
            OP_BEQ:  cls.beq     = 1'b1;
            OP_JAL:  cls.jal     = 1'b1;
            default: cls.unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-lite control FSM; MC_ILLEGAL_TRAP_EN halts on unknown instructions
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel_d,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_bsrc,
    output logic             rf_we,
    output logic [1:0]       rf_wa_sel,
    output logic [1:0]       rf_wd_sel,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    iclass_t          cls;
    alu_op_e          alu_op_i;
    logic             alu_bsrc_i;
    logic             retire;
    logic             trap;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^instr[25:6];

    mc_decode u_decode (
        .op  (instr[31:26]),
        .fn  (instr[5:0]),
        .cls (cls)
    );

    always_comb begin
        alu_op_i   = ALU_ADD;
        alu_bsrc_i = 1'b0;
        if (cls.rtype_alu && instr[5:0] == FN_SUB) begin
            alu_op_i = ALU_SUB;
        end else if (cls.ori) begin
            alu_op_i   = ALU_OR;
            alu_bsrc_i = 1'b1;
        end else if (cls.lui) begin
            alu_op_i   = ALU_LUI;
            alu_bsrc_i = 1'b1;
        end else if (cls.lw || cls.sw) begin
            alu_bsrc_i = 1'b1;
        end else if (cls.beq) begin
            alu_op_i = ALU_SUB;
        end
    end

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        trap      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel_d = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_PLUS4;
        alu_op    = ALU_ADD;
        alu_bsrc  = 1'b0;
        rf_we     = 1'b0;
        rf_wa_sel = WA_RD;
        rf_wd_sel = WD_ALU;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cls.jal) begin
                    rf_we     = 1'b1;
                    rf_wa_sel = WA_RA;
                    rf_wd_sel = WD_PC;
                    pc_we     = 1'b1;
                    pc_src    = PC_JUMP;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end else if (cls.jr) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_REG;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls.unknown) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    trap    = 1'b1;
                    state_d = ST_HALT;
`else
                    retire  = 1'b1;
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op   = alu_op_i;
                alu_bsrc = alu_bsrc_i;
                if (cls.beq) begin
                    pc_we   = zero;
                    pc_src  = PC_BRANCH;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls.lw || cls.sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                // ALU controls stay applied so the data address cannot move while waiting.
                alu_op    = alu_op_i;
                alu_bsrc  = alu_bsrc_i;
                mem_req   = 1'b1;
                mem_sel_d = 1'b1;
                mem_we    = cls.sw;
                if (mem_ready) begin
                    if (cls.sw) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we     = 1'b1;
                rf_wa_sel = cls.rtype_alu ? WA_RD : WA_RT;
                rf_wd_sel = cls.lw ? WD_MDR : WD_ALU;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_FETCH;
        endcase

        if (reset) begin
            state_d   = ST_FETCH;
            retire    = 1'b0;
            trap      = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_sel_d = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_src    = PC_PLUS4;
            alu_op    = ALU_ADD;
            alu_bsrc  = 1'b0;
            rf_we     = 1'b0;
            rf_wa_sel = WA_RD;
            rf_wd_sel = WD_ALU;
        end
    end

    always_comb begin
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q | trap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    logic unused_trap;
    assign unused_trap = trap;
    assign illegal     = 1'b0;
`endif

    assign state_o = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl, honours MC_ILLEGAL_TRAP_EN
module tb_mc_ctrl;

    localparam int CW = 3;
    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;
    localparam logic [31:0] I_ORI1 = 32'h3401_0005, I_ORI2 = 32'h3402_0005, I_BEQ = 32'h1022_0002;
    localparam logic [31:0] I_LW = 32'h8C03_0008, I_SW = 32'hAC03_0004, I_JAL = 32'h0C00_0C00;
    localparam logic [31:0] I_JR = 32'h03E0_0008, I_ADD = 32'h0022_2020, I_SUB = 32'h0022_2822;
    localparam logic [31:0] I_LUI = 32'h3C06_1234, I_BAD = 32'hFC00_0000, I_NOP = 32'h0000_0000;

    logic          clk, reset, zero, mem_ready;
    logic [31:0]   instr;
    logic          mem_req, mem_we, mem_sel_d, ir_we, pc_we, alu_bsrc, rf_we, illegal;
    logic [1:0]    pc_src, alu_op, rf_wa_sel, rf_wd_sel;
    logic [2:0]    state_o;
    logic [CW-1:0] instret;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel_d(mem_sel_d), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op), .alu_bsrc(alu_bsrc),
        .rf_we(rf_we), .rf_wa_sel(rf_wa_sel), .rf_wd_sel(rf_wd_sel),
        .state_o(state_o), .instret(instret), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // vec: {illegal, instret[2:0], state[2:0], req, we, sel, ir_we, pc_we, pc_src, alu_op, bsrc, rf_we, wa, wd}
    typedef struct {
        logic [31:0] ins;
        logic        rdy;
        logic        zr;
        logic        rst;
        logic [21:0] vec;
        logic [21:0] mask;
    } rec_t;

    rec_t          sbq[$];
    rec_t          r;
    logic [CW-1:0] exp_cnt;
    logic          exp_ill;
    int            checks, errors, cyc;

    function automatic logic [21:0] obs();
        return {illegal, instret, state_o, mem_req, mem_we, mem_sel_d, ir_we, pc_we, pc_src,
                alu_op, alu_bsrc, rf_we, rf_wa_sel, rf_wd_sel};
    endfunction

    function automatic rec_t mk(input logic [31:0] ins, input logic rdy, zr, input logic [2:0] st,
                                input logic req, we, sel, irwe, pcwe, input logic [1:0] pcs, aop,
                                input logic bs, rfwe, input logic [1:0] wa, wd);
        rec_t e;
        e.ins  = ins;
        e.rdy  = rdy;
        e.zr   = zr;
        e.rst  = 1'b0;
        e.vec  = {4'b0, st, req, we, sel, irwe, pcwe, pcs, aop, bs, rfwe, wa, wd};
        e.mask = '1;
        if (!req) e.mask[13:12] = 2'b00;
        if (!pcwe) e.mask[9:8] = 2'b00;
        if (st != S_E) e.mask[7:5] = 3'b000;
        if (!rfwe) e.mask[3:0] = 4'b0000;
        return e;
    endfunction

    function automatic rec_t f_r(input logic [31:0] ins, input logic rdy);
        return mk(ins, rdy, 1'b0, S_F, 1'b1, 1'b0, 1'b0, rdy, rdy, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    endfunction

    function automatic rec_t d_r(input logic [31:0] ins, input logic pcwe, input logic [1:0] pcs,
                                 input logic rfwe);
        return mk(ins, 1'b0, 1'b0, S_D, 1'b0, 1'b0, 1'b0, 1'b0, pcwe, pcs, 2'd0, 1'b0, rfwe, 2'd2, 2'd2);
    endfunction

    function automatic rec_t e_r(input logic [31:0] ins, input logic zr, pcwe, input logic [1:0] aop,
                                 input logic bs);
        return mk(ins, 1'b0, zr, S_E, 1'b0, 1'b0, 1'b0, 1'b0, pcwe, 2'd1, aop, bs, 1'b0, 2'd0, 2'd0);
    endfunction

    function automatic rec_t m_r(input logic [31:0] ins, input logic rdy, we);
        return mk(ins, rdy, 1'b0, S_M, 1'b1, we, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    endfunction

    function automatic rec_t w_r(input logic [31:0] ins, input logic [1:0] wa, wd);
        return mk(ins, 1'b0, 1'b0, S_W, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, wa, wd);
    endfunction

    // Every strobe must be exactly 0; state checked only when chk_st is set.
    function automatic rec_t z_r(input logic [31:0] ins, input logic rdy, input logic [2:0] st,
                                 input logic rst, chk_st);
        rec_t e;
        e      = mk(ins, rdy, 1'b0, st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0);
        e.rst  = rst;
        e.mask = '1;
        if (!chk_st) e.mask[17:15] = 3'b000;
        return e;
    endfunction

    task automatic push(input rec_t e, input bit ret);
        e.vec[21:18] = {exp_ill, exp_cnt};
        sbq.push_back(e);
        if (ret) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic drive(input rec_t e);
        instr     = e.ins;
        mem_ready = e.rdy;
        zero      = e.zr;
        reset     = e.rst;
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_cnt = '0;
        exp_ill = 1'b0;
        push(z_r(I_NOP, 1'b1, S_F, 1'b1, 1'b1), 0);
        push(z_r(I_NOP, 1'b1, S_F, 1'b1, 1'b1), 0);
        push(f_r(I_NOP, 1'b0), 0);
        cyc = 0;
        while (sbq.size() != 0) begin
            r = sbq.pop_front();
            drive(r);
            checks++;
            if (((obs() ^ r.vec) & r.mask) !== 22'd0) begin
                errors++;
                $display("FAIL reset cyc %0d got %h exp %h mask %h", cyc, obs(), r.vec, r.mask);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        push(f_r(I_ORI1, 1'b1), 0); push(d_r(I_ORI1, 1'b0, 2'd0, 1'b0), 0);
        push(e_r(I_ORI1, 1'b0, 1'b0, 2'd2, 1'b1), 0); push(w_r(I_ORI1, 2'd1, 2'd0), 1);
        push(f_r(I_ORI2, 1'b1), 0); push(d_r(I_ORI2, 1'b0, 2'd0, 1'b0), 0);
        push(e_r(I_ORI2, 1'b0, 1'b0, 2'd2, 1'b1), 0); push(w_r(I_ORI2, 2'd1, 2'd0), 1);
        push(f_r(I_BEQ, 1'b1), 0); push(d_r(I_BEQ, 1'b0, 2'd0, 1'b0), 0);
        push(e_r(I_BEQ, 1'b1, 1'b1, 2'd1, 1'b0), 1);
        cyc = 0;
        while (sbq.size() != 0) begin
            r = sbq.pop_front();
            drive(r);
            checks++;
            if (((obs() ^ r.vec) & r.mask) !== 22'd0) begin
                errors++;
                $display("FAIL branch cyc %0d got %h exp %h mask %h", cyc, obs(), r.vec, r.mask);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        for (int i = 0; i < 3; i++) push(f_r(I_LW, 1'b0), 0);
        push(f_r(I_LW, 1'b1), 0); push(d_r(I_LW, 1'b0, 2'd0, 1'b0), 0);
        push(e_r(I_LW, 1'b0, 1'b0, 2'd0, 1'b1), 0);
        for (int i = 0; i < 3; i++) push(m_r(I_LW, 1'b0, 1'b0), 0);
        push(m_r(I_LW, 1'b1, 1'b0), 0); push(w_r(I_LW, 2'd1, 2'd1), 1);
        cyc = 0;
        while (sbq.size() != 0) begin
            r = sbq.pop_front();
            drive(r);
            checks++;
            if (((obs() ^ r.vec) & r.mask) !== 22'd0) begin
                errors++;
                $display("FAIL lw_wait cyc %0d got %h exp %h mask %h", cyc, obs(), r.vec, r.mask);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jal_jr();
        push(f_r(I_JAL, 1'b1), 0); push(d_r(I_JAL, 1'b1, 2'd2, 1'b1), 1);
        push(f_r(I_JR, 1'b1), 0);  push(d_r(I_JR, 1'b1, 2'd3, 1'b0), 1);
        cyc = 0;
        while (sbq.size() != 0) begin
            r = sbq.pop_front();
            drive(r);
            checks++;
            if (((obs() ^ r.vec) & r.mask) !== 22'd0) begin
                errors++;
                $display("FAIL jal_jr cyc %0d got %h exp %h mask %h", cyc, obs(), r.vec, r.mask);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        push(f_r(I_ADD, 1'b1), 0); push(d_r(I_ADD, 1'b0, 2'd0, 1'b0), 0);
        push(e_r(I_ADD, 1'b0, 1'b0, 2'd0, 1'b0), 0); push(w_r(I_ADD, 2'd0, 2'd0), 1);
        push(f_r(I_SUB, 1'b1), 0); push(d_r(I_SUB, 1'b0, 2'd0, 1'b0), 0);
        push(e_r(I_SUB, 1'b0, 1'b0, 2'd1, 1'b0), 0); push(w_r(I_SUB, 2'd0, 2'd0), 1);
        push(f_r(I_LUI, 1'b1), 0); push(d_r(I_LUI, 1'b0, 2'd0, 1'b0), 0);
        push(e_r(I_LUI, 1'b0, 1'b0, 2'd3, 1'b1), 0); push(w_r(I_LUI, 2'd1, 2'd0), 1);
        push(f_r(I_BEQ, 1'b1), 0); push(d_r(I_BEQ, 1'b0, 2'd0, 1'b0), 0);
        push(e_r(I_BEQ, 1'b0, 1'b0, 2'd1, 1'b0), 1);
        cyc = 0;
        while (sbq.size() != 0) begin
            r = sbq.pop_front();
            drive(r);
            checks++;
            if (((obs() ^ r.vec) & r.mask) !== 22'd0) begin
                errors++;
                $display("FAIL alu cyc %0d got %h exp %h mask %h", cyc, obs(), r.vec, r.mask);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_sw();
        push(f_r(I_SW, 1'b1), 0); push(d_r(I_SW, 1'b0, 2'd0, 1'b0), 0);
        push(e_r(I_SW, 1'b0, 1'b0, 2'd0, 1'b1), 0); push(m_r(I_SW, 1'b0, 1'b1), 0);
        push(z_r(I_SW, 1'b1, S_M, 1'b1, 1'b0), 0);
        exp_cnt = '0;
        push(f_r(I_SW, 1'b0), 0);
        cyc = 0;
        while (sbq.size() != 0) begin
            r = sbq.pop_front();
            drive(r);
            checks++;
            if (((obs() ^ r.vec) & r.mask) !== 22'd0) begin
                errors++;
                $display("FAIL reset_mid_sw cyc %0d got %h exp %h mask %h", cyc, obs(), r.vec, r.mask);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_instret_wrap();
        for (int i = 0; i < 9; i++) begin
            push(f_r(I_JR, 1'b1), 0);
            push(d_r(I_JR, 1'b1, 2'd3, 1'b0), 1);
        end
        push(f_r(I_JR, 1'b0), 0);
        cyc = 0;
        while (sbq.size() != 0) begin
            r = sbq.pop_front();
            drive(r);
            checks++;
            if (((obs() ^ r.vec) & r.mask) !== 22'd0) begin
                errors++;
                $display("FAIL instret_wrap cyc %0d got %h exp %h mask %h", cyc, obs(), r.vec, r.mask);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        push(f_r(I_BAD, 1'b1), 0);
`ifdef MC_ILLEGAL_TRAP_EN
        push(d_r(I_BAD, 1'b0, 2'd0, 1'b0), 0);
        exp_ill = 1'b1;
        for (int i = 0; i < 3; i++) push(z_r(I_BAD, 1'b1, S_H, 1'b0, 1'b1), 0);
        push(z_r(I_BAD, 1'b1, S_H, 1'b1, 1'b1), 0);
        exp_ill = 1'b0;
        exp_cnt = '0;
`else
        push(d_r(I_BAD, 1'b0, 2'd0, 1'b0), 1);
        push(f_r(I_NOP, 1'b1), 0);
        push(d_r(I_NOP, 1'b0, 2'd0, 1'b0), 1);
`endif
        push(f_r(I_NOP, 1'b0), 0);
        cyc = 0;
        while (sbq.size() != 0) begin
            r = sbq.pop_front();
            drive(r);
            checks++;
            if (((obs() ^ r.vec) & r.mask) !== 22'd0) begin
                errors++;
                $display("FAIL illegal cyc %0d got %h exp %h mask %h", cyc, obs(), r.vec, r.mask);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        instr     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_branch();
        test_lw_wait();
        test_jal_jr();
        test_alu();
        test_reset_mid_sw();
        test_instret_wrap();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog bench did not finish");
        $fatal(1);
    end

endmodule
